// File: rtl/ex_alu_stage.sv
// ============================================================================
// Module      : ex_alu_stage (with helper ex_shifter)
// Description : Registered RV32 execute stage with a 2-entry skid buffer.
//               Optional rotate ops are enabled by defining EX_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_shifter (
    input  logic [31:0] i_data,
    input  logic [4:0]  i_shamt,
    input  logic [1:0]  i_type,
    output logic [31:0] o_result
);
    always_comb begin
        o_result = '0;
        case (i_type)
            2'b00:   o_result = i_data >> i_shamt;
            2'b01:   o_result = i_data << i_shamt;
            2'b10:   o_result = $unsigned($signed(i_data) >>> i_shamt);
            default: o_result = '0;
        endcase
    end
endmodule

module ex_alu_stage #(
    parameter int TAG_W = 5,
    parameter int XLEN  = 32   // only 32 is legal: the shifter is fixed width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_rd,
    output logic             out_zero
);
    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_SLL  = 4'd2;
    localparam logic [3:0] c_OP_SRL  = 4'd3;
    localparam logic [3:0] c_OP_SRA  = 4'd4;
    localparam logic [3:0] c_OP_AND  = 4'd5;
    localparam logic [3:0] c_OP_OR   = 4'd6;
    localparam logic [3:0] c_OP_XOR  = 4'd7;
    localparam logic [3:0] c_OP_SLT  = 4'd8;
    localparam logic [3:0] c_OP_SLTU = 4'd9;
    localparam logic [3:0] c_OP_ROL  = 4'd10;
    localparam logic [3:0] c_OP_ROR  = 4'd11;

    localparam logic [1:0] c_SH_SRL = 2'b00;
    localparam logic [1:0] c_SH_SLL = 2'b01;
    localparam logic [1:0] c_SH_SRA = 2'b10;

    logic [4:0]       w_shamt;
    logic [1:0]       w_sh_type;
    logic [XLEN-1:0]  w_shift_result;
    logic [XLEN-1:0]  w_rot_result;
    logic [XLEN-1:0]  w_result;
    logic             w_zero;
    logic             w_accept;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_result;
    logic [TAG_W-1:0] r_out_rd;
    logic             r_out_zero;
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_result;
    logic [TAG_W-1:0] r_skid_rd;
    logic             r_skid_zero;

    assign w_shamt = in_b[4:0];

    always_comb begin
        w_sh_type = c_SH_SRL;
        case (in_op)
            c_OP_SLL: w_sh_type = c_SH_SLL;
            c_OP_SRA: w_sh_type = c_SH_SRA;
            default:  w_sh_type = c_SH_SRL;
        endcase
    end

    ex_shifter u_shifter (
        .i_data   (in_a),
        .i_shamt  (w_shamt),
        .i_type   (w_sh_type),
        .o_result (w_shift_result)
    );

`ifdef EX_ROTATE_EN
    // A rotate is a left and a right shift by complementary amounts, OR-ed;
    // a complement of 0 is 0 (mod 32), so s=0 yields the operand itself.
    logic [4:0]      w_neg_shamt;
    logic [4:0]      w_rot_l_amt;
    logic [4:0]      w_rot_r_amt;
    logic [XLEN-1:0] w_rot_l;
    logic [XLEN-1:0] w_rot_r;

    assign w_neg_shamt = 5'd0 - w_shamt;
    assign w_rot_l_amt = (in_op == c_OP_ROR) ? w_neg_shamt : w_shamt;
    assign w_rot_r_amt = (in_op == c_OP_ROR) ? w_shamt : w_neg_shamt;

    ex_shifter u_rot_left (
        .i_data   (in_a),
        .i_shamt  (w_rot_l_amt),
        .i_type   (c_SH_SLL),
        .o_result (w_rot_l)
    );

    ex_shifter u_rot_right (
        .i_data   (in_a),
        .i_shamt  (w_rot_r_amt),
        .i_type   (c_SH_SRL),
        .o_result (w_rot_r)
    );

    assign w_rot_result = w_rot_l | w_rot_r;
`else
    assign w_rot_result = '0;
`endif

    always_comb begin
        w_result = '0;
        case (in_op)
            c_OP_ADD:                     w_result = in_a + in_b;
            c_OP_SUB:                     w_result = in_a - in_b;
            c_OP_SLL, c_OP_SRL, c_OP_SRA: w_result = w_shift_result;
            c_OP_AND:                     w_result = in_a & in_b;
            c_OP_OR:                      w_result = in_a | in_b;
            c_OP_XOR:                     w_result = in_a ^ in_b;
            c_OP_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            c_OP_SLTU: w_result = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            c_OP_ROL, c_OP_ROR:           w_result = w_rot_result;
            default:                      w_result = '0;
        endcase
    end

    assign w_zero   = (w_result == '0);
    // Skid empty is the only ready condition, so in_ready stays a flop output.
    assign w_accept = in_valid && !r_skid_valid && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_rd      <= '0;
            r_out_zero    <= 1'b1;
            r_skid_valid  <= 1'b0;
            r_skid_result <= '0;
            r_skid_rd     <= '0;
            r_skid_zero   <= 1'b1;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid) begin
            if (w_accept) begin
                r_out_valid  <= 1'b1;
                r_out_result <= w_result;
                r_out_rd     <= in_rd;
                r_out_zero   <= w_zero;
            end
        end else if (out_ready) begin
            if (r_skid_valid) begin
                r_out_result <= r_skid_result;
                r_out_rd     <= r_skid_rd;
                r_out_zero   <= r_skid_zero;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_result <= w_result;
                r_out_rd     <= in_rd;
                r_out_zero   <= w_zero;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid  <= 1'b1;
            r_skid_result <= w_result;
            r_skid_rd     <= in_rd;
            r_skid_zero   <= w_zero;
        end
    end

    assign in_ready   = !r_skid_valid;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_rd     = r_out_rd;
    assign out_zero   = r_out_zero;

endmodule

`default_nettype wire

// File: tb/tb_ex_alu_stage.sv
// ============================================================================
// Module      : tb_ex_alu_stage
// Description : Self-checking bench for ex_alu_stage (honours EX_ROTATE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_alu_stage;
`ifdef EX_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } ent_t;

    ent_t q[$];
    ent_t m_ent;
    bit   m_acc;
    bit   m_drn;

    always #5 clk = ~clk;

    ex_alu_stage #(.TAG_W(5), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_zero   (out_zero)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] dbl;
        int          s;
        s   = int'(b[4:0]);
        dbl = {a, a};
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << s;
            4'd3:  return a >> s;
            4'd4:  return $unsigned($signed(a) >>> s);
            4'd5:  return a & b;
            4'd6:  return a | b;
            4'd7:  return a ^ b;
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: begin
                dbl = dbl << s;
                return ROT ? dbl[63:32] : 32'd0;
            end
            4'd11: begin
                dbl = dbl >> s;
                return ROT ? dbl[31:0] : 32'd0;
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the stage is a FIFO of depth two; ready while fewer than two held.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            m_acc = in_valid && (q.size() < 2) && !flush;
            m_drn = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (m_drn) void'(q.pop_front());
                if (m_acc) begin
                    m_ent.res = ref_alu(in_op, in_a, in_b);
                    m_ent.rd  = in_rd;
                    q.push_back(m_ent);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk("out_result", out_result, q[0].res);
            chk("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
            chk("out_zero", {31'd0, out_zero}, {31'd0, q[0].res == 32'd0});
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bit ok;
        int n;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        ok       = 1'b0;
        n        = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready && !flush;
            @(posedge clk);
            n++;
        end
        #1 in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: actual=not_accepted expected=accepted tag=%0d", rd);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
        in_a = '0; in_b = '0; in_rd = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_zero", {31'd0, out_zero}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        rst = 1'b0;
        idle(1);

        send(4'd1, 32'h0, 32'h1, 5'd1);             chk("sub_wrap", out_result, 32'hFFFF_FFFF);
        send(4'd8, 32'hFFFF_FFFF, 32'h1, 5'd2);     chk("slt", out_result, 32'd1);
        send(4'd9, 32'hFFFF_FFFF, 32'h1, 5'd3);     chk("sltu", out_result, 32'd0);
        send(4'd7, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 5'd4);
        chk("xor_zero", out_result, 32'd0);
        chk("xor_zero_flag", {31'd0, out_zero}, 32'd1);
        send(4'd2, 32'h8000_0010, 32'hFFFF_FFE4, 5'd5); chk("sll", out_result, 32'h0000_0100);
        send(4'd3, 32'h8000_0010, 32'hFFFF_FFE4, 5'd6); chk("srl", out_result, 32'h0800_0001);
        send(4'd4, 32'h8000_0010, 32'hFFFF_FFE4, 5'd7); chk("sra", out_result, 32'hF800_0001);
        send(4'd11, 32'h0000_0001, 32'd1, 5'd8);    chk("ror1", out_result, ROT ? 32'h8000_0000 : 32'd0);
        send(4'd10, 32'h8000_0001, 32'd4, 5'd9);    chk("rol4", out_result, ROT ? 32'h0000_0018 : 32'd0);
        send(4'd10, 32'h1234_5678, 32'd0, 5'd10);   chk("rol0", out_result, ROT ? 32'h1234_5678 : 32'd0);
        send(4'd11, 32'h1234_5678, 32'h20, 5'd11);  chk("ror0", out_result, ROT ? 32'h1234_5678 : 32'd0);
        send(4'd13, 32'd5, 32'd6, 5'd12);           chk("reserved", out_result, 32'd0);
        send(4'd0, 32'hFFFF_FFFF, 32'd2, 5'd13);    chk("add_wrap", out_result, 32'd1);
        idle(2);

        // Sweep every opcode under an irregular consumer pattern.
        for (int i = 0; i < 32; i++) begin
            out_ready = (i % 3) != 1;
            send(4'(i % 16), 32'h9E37_79B9 * (i + 1), 32'h7F4A_7C15 ^ (i * 32'h0101_0101), 5'(i));
        end
        out_ready = 1'b1;
        idle(3);

        // Backpressure: four bundles while the consumer is stalled.
        out_ready = 1'b0;
        fork
            begin
                for (int t = 1; t <= 4; t++) send(4'd0, 32'(t * 10), 32'(t), 5'(t));
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
                chk("bp_head_tag", {27'd0, out_rd}, 32'd1);
                out_ready = 1'b1;
                for (int k = 1; k <= 4; k++) begin
                    @(negedge clk);
                    #1;
                    chk("bp_order_valid", {31'd0, out_valid}, 32'd1);
                    chk("bp_order_tag", {27'd0, out_rd}, 32'(k));
                end
            end
        join
        idle(2);

        // Flush with the skid full and a new bundle offered.
        out_ready = 1'b0;
        send(4'd0, 32'd1, 32'd1, 5'd5);
        send(4'd0, 32'd2, 32'd2, 5'd6);
        flush = 1'b1; in_valid = 1'b1; in_op = 4'd0; in_a = 32'd9; in_b = 32'd0; in_rd = 5'd9;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        idle(3);

        // Flush coinciding with a drain.
        out_ready = 1'b0;
        send(4'd6, 32'hF0, 32'h0F, 5'd14);
        send(4'd5, 32'hF0, 32'h3C, 5'd15);
        out_ready = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_drain_valid", {31'd0, out_valid}, 32'd0);
        idle(2);

        // Reset while both entries are occupied.
        out_ready = 1'b0;
        send(4'd0, 32'd8, 32'd8, 5'd20);
        send(4'd0, 32'd9, 32'd9, 5'd21);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_zero", {31'd0, out_zero}, 32'd1);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        send(4'd0, 32'd3, 32'd4, 5'd7);
        chk("post_rst_add", out_result, 32'd7);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
